interrupt_controller: RTL and testbench

Consumer end of the interrupt line driven by the Timer and other peripherals in the single-cycle MIPS.
- Edge-detects source lines and latches them into a pending register.
- Applies a software mask and picks the highest-priority source.
- Raises a request to the datapath, which takes it at an instruction boundary. The block then saves the EPC and supplies the handler vector.
- Holds off further requests until eret; no nesting.

---
 rtl/irq_pkg.sv | 40 ++++
 rtl/irq_priority_encoder.sv | 32 +++
 rtl/interrupt_controller.sv | 147 ++++++++++++++
 tb/tb_interrupt_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared types and constants for the interrupt controller:
//                FSM state encoding, width helpers and vector defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Controller state, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_HANDLER = 2'd2
    } irq_state_t;

    // Default handler address of source 0 and byte spacing between vectors
    localparam logic [31:0] DEFAULT_VECTOR_BASE   = 32'h0000_0080;
    localparam int          DEFAULT_VECTOR_STRIDE = 8;

    // The Timer is wired to the lowest index, which is also the top priority
    localparam int TIMER_IRQ_BIT = 0;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Source-id width, never narrower than one bit so a single-source build still has a port
    function automatic int id_width(input int num_sources);
        return (clog2(num_sources) < 1) ? 1 : clog2(num_sources);
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : irq_priority_encoder
//  Description : Combinational fixed-priority encoder. The lowest set bit of
//                the request vector wins; valid flags that any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int ID_W        = 2
) (
    input  logic [NUM_SOURCES-1:0] req,
    output logic [ID_W-1:0]        id,
    output logic                   valid
);

    // Scan from the top down so the last hit, the lowest index, is the one kept
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_SOURCES - 1; i >= TIMER_IRQ_BIT; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : irq_priority_encoder
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Edge-detecting, maskable, fixed-priority interrupt controller
//                for a single-cycle MIPS datapath. One interrupt is serviced
//                at a time; eret re-opens the controller for the next source.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SOURCES   = 4,
    parameter logic [31:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
    parameter int          VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE,
    localparam int         ID_W          = id_width(NUM_SOURCES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   mask_write,
    input  logic [NUM_SOURCES-1:0] mask_data,
    input  logic [31:0]            pc_current,
    input  logic                   instr_commit,
    input  logic                   eret,
    output logic                   irq_request,
    output logic [31:0]            irq_vector,
    output logic [ID_W-1:0]        cause_id,
    output logic [31:0]            epc,
    output logic [NUM_SOURCES-1:0] pending,
    output logic                   in_handler
);

    irq_state_t             r_state;
    irq_state_t             w_next_state;

    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] r_mask;
    logic [NUM_SOURCES-1:0] r_irq_prev;
    logic [ID_W-1:0]        r_cause;
    logic [31:0]            r_vector;
    logic [31:0]            r_epc;

    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_eligible;
    logic [NUM_SOURCES-1:0] w_clear;
    logic [ID_W-1:0]        w_win_id;
    logic                   w_win_valid;
    logic [31:0]            w_win_vector;
    logic                   w_load;
    logic                   w_take;
    logic                   w_withdraw;

    // A level held high produces one rise only, so it is counted once
    assign w_rise     = irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & r_mask;

    irq_priority_encoder #(
        .NUM_SOURCES (NUM_SOURCES),
        .ID_W        (ID_W)
    ) u_priority_encoder (
        .req   (w_eligible),
        .id    (w_win_id),
        .valid (w_win_valid)
    );

    // 32-bit arithmetic; wraps silently for very large bases
    assign w_win_vector = VECTOR_BASE + (32'(w_win_id) * 32'(VECTOR_STRIDE));

    // Commit has precedence over a same-cycle mask write that would withdraw
    assign w_load     = (r_state == IDLE) && w_win_valid;
    assign w_take     = (r_state == REQUEST) && instr_commit;
    assign w_withdraw = (r_state == REQUEST) && !instr_commit
                        && mask_write && !mask_data[r_cause];
    assign w_clear    = w_take ? (NUM_SOURCES'(1) << r_cause) : '0;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: no nesting, eret is the only way out of the handler
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_next_state = REQUEST;
                end
            end
            REQUEST: begin
                if (w_take) begin
                    w_next_state = IN_HANDLER;
                end else if (w_withdraw) begin
                    w_next_state = IDLE;
                end
            end
            IN_HANDLER: begin
                if (eret) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Pending/mask/edge-history plus the cause, vector and EPC captures
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_irq_prev <= '0;
            r_cause    <= '0;
            r_vector   <= VECTOR_BASE;
            r_epc      <= '0;
        end else begin
            r_irq_prev <= irq_in;
            // A rise on the bit being taken survives the clear
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            if (mask_write) begin
                r_mask <= mask_data;
            end
            // Frozen for the whole request and handler, even if a better source arrives
            if (w_load) begin
                r_cause  <= w_win_id;
                r_vector <= w_win_vector;
            end
            if (w_take) begin
                r_epc <= pc_current;
            end
        end
    end

    assign irq_request = (r_state == REQUEST);
    assign in_handler  = (r_state == IN_HANDLER);
    assign irq_vector  = r_vector;
    assign cause_id    = r_cause;
    assign epc         = r_epc;
    assign pending     = r_pending;

endmodule : interrupt_controller
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Self-checking bench: directed vector table, hand-written
//                corner sequences and randomized traffic against a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic        clock;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_write;
    logic [3:0]  mask_data;
    logic [31:0] pc_current;
    logic        instr_commit;
    logic        eret;
    logic        irq_request;
    logic [31:0] irq_vector;
    logic [1:0]  cause_id;
    logic [31:0] epc;
    logic [3:0]  pending;
    logic        in_handler;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clock        (clock),
        .reset        (reset),
        .irq_in       (irq_in),
        .mask_write   (mask_write),
        .mask_data    (mask_data),
        .pc_current   (pc_current),
        .instr_commit (instr_commit),
        .eret         (eret),
        .irq_request  (irq_request),
        .irq_vector   (irq_vector),
        .cause_id     (cause_id),
        .epc          (epc),
        .pending      (pending),
        .in_handler   (in_handler)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // "waiting" = a request is being presented, "servicing" = handler running
    logic [3:0]  m_prev, m_pend, m_mask;
    bit          m_waiting, m_servicing;
    int          m_cause;
    logic [31:0] m_vec, m_epc;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0;
        m_waiting = 0; m_servicing = 0;
        m_cause = 0; m_vec = 32'h80; m_epc = '0;
    endtask

    task automatic model_step(input logic [3:0] irq, input logic mw, input logic [3:0] md,
                              input logic [31:0] pc, input logic cm, input logic er);
        logic [3:0] taken_bit;
        logic [3:0] elig;
        logic [3:0] lowest;
        taken_bit = '0;
        elig      = m_pend & m_mask;
        if (m_waiting) begin
            if (cm) begin
                m_epc       = pc;
                taken_bit   = 4'b0001 << m_cause;
                m_waiting   = 0;
                m_servicing = 1;
            end else if (mw && !md[m_cause]) begin
                m_waiting = 0;
            end
        end else if (m_servicing) begin
            if (er) m_servicing = 0;
        end else if (elig != 0) begin
            lowest    = elig & (~elig + 4'd1);
            m_cause   = $clog2(lowest);
            m_vec     = 32'h80 + 32'(m_cause) * 32'd8;
            m_waiting = 1;
        end
        m_pend = (m_pend & ~taken_bit) | (irq & ~m_prev);
        if (mw) m_mask = md;
        m_prev = irq;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.irq_request", 32'(irq_request), 32'(m_waiting));
        chk("model.irq_vector", irq_vector, m_vec);
        chk("model.cause_id", 32'(cause_id), 32'(m_cause));
        chk("model.epc", epc, m_epc);
        chk("model.pending", 32'(pending), 32'(m_pend));
        chk("model.in_handler", 32'(in_handler), 32'(m_servicing));
    endtask

    // Called at a negedge: drive inputs, let one rising edge happen, check at the next negedge
    task automatic cycle(input logic [3:0] irq, input logic mw, input logic [3:0] md,
                         input logic [31:0] pc, input logic cm, input logic er);
        irq_in = irq; mask_write = mw; mask_data = md;
        pc_current = pc; instr_commit = cm; eret = er;
        @(posedge clock);
        model_step(irq, mw, md, pc, cm, er);
        @(negedge clock);
        check_model();
    endtask

    task automatic idle_cycle();
        cycle(4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  irq;
        logic        mw;
        logic [3:0]  md;
        logic [31:0] pc;
        logic        cm;
        logic        er;
        logic        req;
        logic [31:0] vec;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [3:0]  pend;
        logic        ih;
    } vec_t;

    vec_t tbl [22];

    int takes;
    logic prev_ih;

    initial begin
        // Timer pulse and take
        tbl[0]  = '{4'b0000, 1'b1, 4'b0001, 32'h0,        1'b0, 1'b0, 1'b0, 32'h80, 2'd0, 32'h0,        4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h80, 2'd0, 32'h0,        4'b0001, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h80, 2'd0, 32'h0,        4'b0001, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h80, 2'd0, 32'h0040_0010, 4'b0000, 1'b1};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h80, 2'd0, 32'h0040_0010, 4'b0000, 1'b0};
        // Priority and no nesting
        tbl[5]  = '{4'b0110, 1'b1, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0, 32'h80, 2'd0, 32'h0040_0010, 4'b0110, 1'b0};
        tbl[6]  = '{4'b0110, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h88, 2'd1, 32'h0040_0010, 4'b0110, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h88, 2'd1, 32'h0040_0100, 4'b0100, 1'b1};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h88, 2'd1, 32'h0040_0100, 4'b0100, 1'b1};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h88, 2'd1, 32'h0040_0100, 4'b0100, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h90, 2'd2, 32'h0040_0100, 4'b0100, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 32'h0040_0200, 1'b1, 1'b0, 1'b0, 32'h90, 2'd2, 32'h0040_0200, 4'b0000, 1'b1};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h90, 2'd2, 32'h0040_0200, 4'b0000, 1'b0};
        // Masking: pending kept while masked, request follows the unmask
        tbl[13] = '{4'b1000, 1'b1, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h90, 2'd2, 32'h0040_0200, 4'b1000, 1'b0};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h90, 2'd2, 32'h0040_0200, 4'b1000, 1'b0};
        tbl[15] = '{4'b0000, 1'b1, 4'b1000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h90, 2'd2, 32'h0040_0200, 4'b1000, 1'b0};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h98, 2'd3, 32'h0040_0200, 4'b1000, 1'b0};
        // Withdraw, then commit beating a same-cycle masking write
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h98, 2'd3, 32'h0040_0200, 4'b1000, 1'b0};
        tbl[18] = '{4'b0000, 1'b1, 4'b1000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h98, 2'd3, 32'h0040_0200, 4'b1000, 1'b0};
        tbl[19] = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h98, 2'd3, 32'h0040_0200, 4'b1000, 1'b0};
        tbl[20] = '{4'b0000, 1'b1, 4'b0000, 32'h0040_0300, 1'b1, 1'b0, 1'b0, 32'h98, 2'd3, 32'h0040_0300, 4'b0000, 1'b1};
        tbl[21] = '{4'b0000, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h98, 2'd3, 32'h0040_0300, 4'b0000, 1'b0};

        // Reset
        reset = 1'b1;
        irq_in = '0; mask_write = 0; mask_data = '0;
        pc_current = '0; instr_commit = 0; eret = 0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset.irq_request", 32'(irq_request), 32'd0);
        chk("reset.irq_vector", irq_vector, 32'h80);
        chk("reset.cause_id", 32'(cause_id), 32'd0);
        chk("reset.epc", epc, 32'd0);
        chk("reset.pending", 32'(pending), 32'd0);
        chk("reset.in_handler", 32'(in_handler), 32'd0);

        // Directed table
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].irq, tbl[i].mw, tbl[i].md, tbl[i].pc, tbl[i].cm, tbl[i].er);
            chk($sformatf("tbl%0d.irq_request", i), 32'(irq_request), 32'(tbl[i].req));
            chk($sformatf("tbl%0d.irq_vector", i), irq_vector, tbl[i].vec);
            chk($sformatf("tbl%0d.cause_id", i), 32'(cause_id), 32'(tbl[i].cause));
            chk($sformatf("tbl%0d.epc", i), epc, tbl[i].epc);
            chk($sformatf("tbl%0d.pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d.in_handler", i), 32'(in_handler), 32'(tbl[i].ih));
        end

        // Held level: irq_in[0] high for 10 cycles, commit/eret always on -> one take
        cycle(4'b0000, 1'b1, 4'b0001, 32'h0, 1'b0, 1'b0);
        takes = 0;
        prev_ih = in_handler;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0001, 1'b0, 4'b0000, 32'h0050_0000 + 32'(i), 1'b1, 1'b1);
            if (in_handler && !prev_ih) takes++;
            prev_ih = in_handler;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);
            if (in_handler && !prev_ih) takes++;
            prev_ih = in_handler;
        end
        chk("held_level.takes", 32'(takes), 32'd1);

        // Re-arm: pulse during the handler is kept and requested after eret
        cycle(4'b0001, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
        idle_cycle();
        cycle(4'b0000, 1'b0, 4'b0000, 32'h0060_0000, 1'b1, 1'b0);
        chk("rearm.in_handler", 32'(in_handler), 32'd1);
        cycle(4'b0001, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
        chk("rearm.pending", 32'(pending), 32'b0001);
        cycle(4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1);
        chk("rearm.after_eret_req", 32'(irq_request), 32'd0);
        idle_cycle();
        chk("rearm.request", 32'(irq_request), 32'd1);

        // Async reset mid-REQUEST, between clock edges
        #2;
        reset = 1'b1;
        #1;
        chk("areset.irq_request", 32'(irq_request), 32'd0);
        chk("areset.pending", 32'(pending), 32'd0);
        chk("areset.epc", epc, 32'd0);
        chk("areset.in_handler", 32'(in_handler), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        cycle(4'b0000, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);
        chk("areset.eret_ignored", 32'(in_handler), 32'd0);
        idle_cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  r_irq, r_md;
            logic        r_mw, r_cm, r_er;
            logic [31:0] r_pc;
            r_irq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            r_mw  = ($urandom_range(0, 7) == 0);
            r_md  = 4'($urandom);
            r_pc  = $urandom;
            r_cm  = ($urandom_range(0, 1) == 0);
            r_er  = ($urandom_range(0, 3) == 0);
            cycle(r_irq, r_mw, r_md, r_pc, r_cm, r_er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_interrupt_controller
`default_nettype wire
